ls_updn_counter: RTL and testbench
==================================

LS_UPDN_COUNTER -- requirements
Module: ls_updn_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 2**WIDTH: count sequence length, legal range 2..2**WIDTH.
REQ-003 clk  input  1  single clock, all state changes on its rising edge.
REQ-004 n_clr  input  1  reset, synchronous and active-low.
REQ-005 din  input  WIDTH  parallel load value.
REQ-006 enp  input  1  count enable, parallel.
REQ-007 ent  input  1  count enable, trickle; also gates rco.
REQ-008 n_load  input  1  synchronous parallel load, active-low.
REQ-009 up  input  1  direction: 1 counts up, 0 counts down.
REQ-010 one_shot  input  1  mode: 1 stops at terminal count, 0 wraps (free-run).
REQ-011 q  output  WIDTH  current count.
REQ-012 rco  output  1  ripple carry out, combinational.
REQ-013 tc_pulse  output  1  registered one-cycle terminal-event strobe.
REQ-014 halted  output  1  high while in HALT state.

Function
REQ-015 Terminal value TV SHALL be MODULUS-1 when up=1 and 0 when up=0.
REQ-016 Per-edge priority SHALL be: clear > load > count > hold.
REQ-017 Load (n_load=0) SHALL set q to din, saturated to MODULUS-1 when din >= MODULUS, independent of enp/ent/state.
REQ-018 Load SHALL force state to RUN.
REQ-019 Count step SHALL occur when n_load=1, enp=1, ent=1 and state is RUN; otherwise q holds.
REQ-020 A non-terminal step SHALL change q by +1 (up) or -1 (down).
REQ-021 A step from TV in free-run SHALL wrap: up to 0, down to MODULUS-1.
REQ-022 A step from TV in one-shot SHALL leave q at TV and move state RUN -> HALT.
REQ-023 HALT SHALL be left only by load or clear; changes on up/one_shot do not leave HALT.
REQ-024 rco SHALL equal ent AND (q == TV) for the current up value, regardless of state.
REQ-025 tc_pulse SHALL be high for exactly the cycle after any step taken from TV (wrap or halt), low otherwise.
REQ-026 Changing up mid-count SHALL take effect on the next step with no extra latency; q unchanged by the change itself.
REQ-027 Arithmetic SHALL be modulo MODULUS; q never holds a value >= MODULUS.

Reset
REQ-028 On a rising clk edge with n_clr=0: q=0, state=RUN, tc_pulse=0, all other inputs ignored.
REQ-029 Reset SHALL have no effect between clock edges; q is undefined before the first clocked reset.
REQ-030 Reset asserted while in HALT or mid-count SHALL act identically to REQ-028.

Configuration
REQ-031 Macro LS_UPDN_MATCH_EN SHALL, when defined, add input match_val (WIDTH) and output match (1).
REQ-032 With LS_UPDN_MATCH_EN: match SHALL be registered, high for one cycle after any edge at which q becomes equal to match_val via count or load; cleared by reset.
REQ-033 Without LS_UPDN_MATCH_EN: match_val and match ports SHALL be absent, no compare logic present.

Structure
REQ-034 Package ls_counter_pkg SHALL hold the state typedef (RUN, HALT) and direction constants CNT_UP=1, CNT_DN=0.
REQ-035 Sub-module ls_counter_term SHALL compute TV equality (q, up -> at_tv), instantiated once.

Verification
REQ-036 WIDTH=4, MODULUS=10, up=1, free-run, enp=ent=1 from 0: q 0..9,0; rco high at q=9; tc_pulse one cycle after 9->0 step.
REQ-037 Same params, up=0, load din=3, count: q 3,2,1,0,9; tc_pulse after 0->9 step.
REQ-038 one_shot=1, up=1, load 7, count: q 7,8,9,9,9; halted=1 from cycle after 9; load din=2 -> q=2, halted=0.
REQ-039 Load din=12 with MODULUS=10 -> q=9; n_clr=0 together with n_load=0 and enp=ent=1 -> q=0.
REQ-040 ent=0, enp=1 at q=9 up: q holds, rco=0; ent=1, enp=0: q holds, rco=1.
REQ-041 LS_UPDN_MATCH_EN defined, match_val=5, count up from 0: match high exactly the cycle after q becomes 5.

Source files
------------

// File: rtl/ls_counter_pkg.sv
// Shared definitions for the loadable up/down counter: state encoding,
// direction constants and the load saturation helper.
package ls_counter_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } cnt_state_e;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Operands are 17 bits wide so a modulus of 2**16 is still representable.
  function automatic logic [16:0] sat_load(input logic [16:0] din_ext,
                                           input logic [16:0] modulus);
    logic [16:0] res;
    if (din_ext >= modulus) begin
      res = modulus - 17'd1;
    end else begin
      res = din_ext;
    end
    return res;
  endfunction

endpackage

// File: rtl/ls_updn_counter_if.sv
// Counter control/status bundle. Define LS_UPDN_MATCH_EN to add the
// match_val compare input and the match strobe.
interface ls_updn_counter_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             enp;
  logic             ent;
  logic             n_load;
  logic             up;
  logic             one_shot;
  logic [WIDTH-1:0] q;
  logic             rco;
  logic             tc_pulse;
  logic             halted;

`ifdef LS_UPDN_MATCH_EN
  logic [WIDTH-1:0] match_val;
  logic             match;

  modport master (
    output din, enp, ent, n_load, up, one_shot, match_val,
    input  q, rco, tc_pulse, halted, match
  );

  modport slave (
    input  din, enp, ent, n_load, up, one_shot, match_val,
    output q, rco, tc_pulse, halted, match
  );
`else
  modport master (
    output din, enp, ent, n_load, up, one_shot,
    input  q, rco, tc_pulse, halted
  );

  modport slave (
    input  din, enp, ent, n_load, up, one_shot,
    output q, rco, tc_pulse, halted
  );
`endif

endinterface

// File: rtl/ls_counter_term.sv
// Terminal-value detector: high when q sits on the terminal value for the
// current direction (MODULUS-1 counting up, zero counting down).
module ls_counter_term
  import ls_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  output logic             at_tv_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  // Direction-dependent terminal compare.
  always_comb begin
    if (up_i == CNT_DN) begin
      at_tv_o = (q_i == {WIDTH{1'b0}});
    end else begin
      at_tv_o = (q_i == MAX_V);
    end
  end

endmodule

// File: rtl/ls_updn_counter.sv
// Modulo-MODULUS up/down counter with parallel load, free-run/one-shot modes
// and a registered terminal strobe. LS_UPDN_MATCH_EN adds a match strobe.
module ls_updn_counter
  import ls_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             n_clr,
  ls_updn_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [16:0]      MOD_V = 17'(MODULUS);

  cnt_state_e       state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             at_tv_s;
  logic             load_s;
  logic             step_s;
  logic             halt_step_s;
  logic [WIDTH-1:0] load_val_s;

  ls_counter_term #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_term (
    .q_i     (q_q),
    .up_i    (bus.up),
    .at_tv_o (at_tv_s)
  );

  assign load_val_s = WIDTH'(sat_load(17'(bus.din), MOD_V));

  // Next count: load wins over a step; a one-shot step from TV keeps q.
  always_comb begin
    load_s      = ~bus.n_load;
    step_s      = bus.n_load & bus.enp & bus.ent & (state_q == RUN);
    halt_step_s = step_s & at_tv_s & bus.one_shot;
    tc_d        = step_s & at_tv_s;
    q_d         = q_q;
    if (load_s) begin
      q_d = load_val_s;
    end else if (step_s) begin
      if (at_tv_s) begin
        if (bus.one_shot) begin
          q_d = q_q;
        end else if (bus.up == CNT_UP) begin
          q_d = {WIDTH{1'b0}};
        end else begin
          q_d = MAX_V;
        end
      end else if (bus.up == CNT_UP) begin
        q_d = q_q + WIDTH'(1);
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count register, terminal strobe and RUN/HALT state.
  always_ff @(posedge clk) begin
    if (!n_clr) begin
      state_q <= RUN;
      q_q     <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
      case (state_q)
        RUN: begin
          if (halt_step_s) begin
            state_q <= HALT;
          end else begin
            state_q <= RUN;
          end
        end
        HALT: begin
          if (load_s) begin
            state_q <= RUN;
          end else begin
            state_q <= HALT;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.q        = q_q;
  assign bus.tc_pulse = tc_q;
  assign bus.halted   = (state_q == HALT);
  assign bus.rco      = bus.ent & at_tv_s;

`ifdef LS_UPDN_MATCH_EN
  logic match_q;
  logic match_d;

  // A halting step leaves q unchanged, so it never counts as reaching match_val.
  always_comb begin
    match_d = (load_s | (step_s & ~halt_step_s)) & (q_d == bus.match_val);
  end

  // Match strobe register.
  always_ff @(posedge clk) begin
    if (!n_clr) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_ls_updn_counter.sv
// Directed scoreboard bench for ls_updn_counter with WIDTH=4, MODULUS=10.
// With LS_UPDN_MATCH_EN defined the match strobe is also checked (match_val=5).
module tb_ls_updn_counter;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic       rco;
    logic       tc;
    logic       halted;
    logic       match;
  } exp_t;

  logic clk;
  logic n_clr;
  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;
  int   vec_idx;

  ls_updn_counter_if #(.WIDTH(4)) bus ();

  ls_updn_counter #(
    .WIDTH   (4),
    .MODULUS (10)
  ) dut (
    .clk   (clk),
    .n_clr (n_clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx,
                     input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // One clock of stimulus; expectations describe outputs just after the edge.
  task automatic v(input int clr_n, input int ld_n, input int d, input int ep,
                   input int et, input int u, input int os,
                   input int eq, input int er, input int etc, input int eh,
                   input int em);
    exp_t e;
    @(negedge clk);
    n_clr        = 1'(clr_n);
    bus.n_load   = 1'(ld_n);
    bus.din      = 4'(d);
    bus.enp      = 1'(ep);
    bus.ent      = 1'(et);
    bus.up       = 1'(u);
    bus.one_shot = 1'(os);
    e.idx    = vec_idx;
    e.q      = 4'(eq);
    e.rco    = 1'(er);
    e.tc     = 1'(etc);
    e.halted = 1'(eh);
    e.match  = 1'(em);
    sb_q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: pops one expectation per clock once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("q",        e.idx, 16'(bus.q),        16'(e.q));
        chk("rco",      e.idx, 16'(bus.rco),      16'(e.rco));
        chk("tc_pulse", e.idx, 16'(bus.tc_pulse), 16'(e.tc));
        chk("halted",   e.idx, 16'(bus.halted),   16'(e.halted));
`ifdef LS_UPDN_MATCH_EN
        chk("match",    e.idx, 16'(bus.match),    16'(e.match));
`endif
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    vec_idx = 0;
    n_clr = 1'b0;
    bus.n_load = 1'b1;
    bus.din = 4'd0;
    bus.enp = 1'b0;
    bus.ent = 1'b0;
    bus.up = 1'b1;
    bus.one_shot = 1'b0;
`ifdef LS_UPDN_MATCH_EN
    bus.match_val = 4'd5;
`endif
    //  clr ld  din enp ent up os |  q rco tc  h  m
    v(0, 1,  0, 1, 1, 1, 0,    0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      v(1, 1, 0, 1, 1, 1, 0,   i, (i == 9) ? 1 : 0, 0, 0, (i == 5) ? 1 : 0);
    end
    v(1, 1,  0, 1, 1, 1, 0,    0, 0, 1, 0, 0);
    v(1, 1,  0, 1, 1, 1, 0,    1, 0, 0, 0, 0);
    // Down count from a load of 3, wrapping 0 -> 9.
    v(1, 0,  3, 1, 1, 0, 0,    3, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 0, 0,    2, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 0, 0,    1, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 0, 0,    0, 1, 0, 0, 0);
    v(1, 1,  0, 1, 1, 0, 0,    9, 0, 1, 0, 0);
    v(1, 1,  0, 1, 1, 0, 0,    8, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 0,    9, 1, 0, 0, 0);
    v(1, 1,  0, 1, 1, 0, 0,    8, 0, 0, 0, 0);
    // One-shot from 7, then HALT survives direction/mode changes.
    v(1, 0,  7, 1, 1, 1, 1,    7, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    8, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    9, 1, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    9, 1, 1, 1, 0);
    v(1, 1,  0, 1, 1, 1, 1,    9, 1, 0, 1, 0);
    v(1, 1,  0, 1, 1, 0, 1,    9, 0, 0, 1, 0);
    v(1, 1,  0, 1, 1, 1, 0,    9, 1, 0, 1, 0);
    v(1, 0,  2, 1, 1, 1, 1,    2, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    3, 0, 0, 0, 0);
    // Halt again, then clear while halted with load and enables active.
    v(1, 0,  8, 1, 1, 1, 1,    8, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    9, 1, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    9, 1, 1, 1, 0);
    v(0, 0,  4, 1, 1, 1, 1,    0, 0, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 1,    1, 0, 0, 0, 0);
    // Load saturation and enable gating at q=9.
    v(1, 0, 12, 1, 1, 1, 0,    9, 1, 0, 0, 0);
    v(1, 0, 15, 1, 1, 1, 0,    9, 1, 0, 0, 0);
    v(1, 0, 10, 0, 0, 1, 0,    9, 0, 0, 0, 0);
    v(1, 1,  0, 1, 0, 1, 0,    9, 0, 0, 0, 0);
    v(1, 1,  0, 0, 1, 1, 0,    9, 1, 0, 0, 0);
    v(1, 1,  0, 1, 1, 1, 0,    0, 0, 1, 0, 0);
    // Match via load, then no re-fire while holding.
    v(1, 0,  5, 0, 1, 1, 0,    5, 0, 0, 0, 1);
    v(1, 1,  0, 0, 1, 1, 0,    5, 0, 0, 0, 0);
    v(1, 0,  1, 1, 1, 0, 0,    1, 0, 0, 0, 0);

    for (int k = 0; k < 5 && sb_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
